dcache_controller: RTL and testbench

- Data-cache controller for the pipelined RISC-V core. Sits in the MEM stage and responds to the MemRead/MemWrite requests that the main decoder issues for lw/sw.
- Returns a 32-bit load word and a stall.
- On a miss it drives the off-chip data-memory line interface: write-back of dirty victims, then refill.
- Organisation: 2-way set-associative, write-back, write-allocate, LRU replacement.

---
 rtl/dcache_controller_pkg.sv | 37 +++
 rtl/dcache_sram.sv | 77 +++++++
 rtl/dcache_controller.sv | 223 ++++++++++++++++++++++
 tb/tb_dcache_controller.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_controller_pkg.sv
// Shared definitions for the data-cache controller: core opcode/ALUOp constants,
// address-field widths, miss-FSM state encoding and the victim-selection rule.
package dcache_controller_pkg;

  // Main-decoder constants shared with the rest of the core.
  localparam logic [6:0] OpcLoad     = 7'b0000011;
  localparam logic [6:0] OpcStore    = 7'b0100011;
  localparam logic [6:0] OpcOpImm    = 7'b0010011;
  localparam logic [6:0] OpcOp       = 7'b0110011;
  localparam logic [6:0] OpcBranch   = 7'b1100011;
  localparam logic [1:0] AluOpAdd    = 2'b00;
  localparam logic [1:0] AluOpBranch = 2'b01;
  localparam logic [1:0] AluOpFunct  = 2'b10;

  // Address fields: tag | index | word | byte.
  localparam int unsigned WordW       = 32;
  localparam int unsigned OffsetW     = 5;
  localparam int unsigned WordSelW    = 3;
  localparam int unsigned DefaultSets = 16;
  localparam int unsigned DefaultIdxW = 4;
  localparam int unsigned DefaultTagW = 23;

  // Miss-handling FSM states.
  localparam logic [2:0] StIdle      = 3'd0;
  localparam logic [2:0] StMiss      = 3'd1;
  localparam logic [2:0] StWriteback = 3'd2;
  localparam logic [2:0] StRefill    = 3'd3;
  localparam logic [2:0] StDone      = 3'd4;

  // Invalid ways are filled first (way0 before way1); otherwise the LRU way goes.
  function automatic logic pick_victim(input logic [1:0] valid, input logic lru);
    if (!valid[0]) return 1'b0;
    if (!valid[1]) return 1'b1;
    return lru;
  endfunction

endpackage

// File: rtl/dcache_sram.sv
// Two-way tag/data/valid/dirty/LRU storage. Reads are combinational on rd_idx_i,
// writes land on the clock edge into the selected way of wr_idx_i.
module dcache_sram #(
  parameter int unsigned SETS   = 16,
  parameter int unsigned LINE_W = 256,
  parameter int unsigned TAG_W  = 23,
  parameter int unsigned IDX_W  = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  // Lookup port
  input  logic [IDX_W-1:0]       rd_idx_i,
  input  logic [TAG_W-1:0]       rd_tag_i,
  output logic                   hit_o,
  output logic                   hit_way_o,
  output logic [1:0]             way_valid_o,
  output logic [1:0]             way_dirty_o,
  output logic [1:0][TAG_W-1:0]  way_tag_o,
  output logic [1:0][LINE_W-1:0] way_line_o,
  output logic                   lru_o,
  // Write port
  input  logic [IDX_W-1:0]       wr_idx_i,
  input  logic                   line_we_i,
  input  logic                   wr_way_i,
  input  logic [TAG_W-1:0]       wr_tag_i,
  input  logic [LINE_W-1:0]      wr_line_i,
  input  logic                   wr_dirty_i,
  input  logic                   lru_we_i,
  input  logic                   lru_way_i
);

  logic [1:0][TAG_W-1:0]  tag_q  [SETS];
  logic [1:0][LINE_W-1:0] line_q [SETS];
  logic [SETS-1:0][1:0]   valid_q;
  logic [SETS-1:0][1:0]   dirty_q;
  logic [SETS-1:0]        lru_q;
  logic [1:0]             match;

  // Tag and data arrays carry no reset; the valid bits gate every use of them.
  always_ff @(posedge clk_i) begin
    if (line_we_i) begin
      tag_q[wr_idx_i][wr_way_i]  <= wr_tag_i;
      line_q[wr_idx_i][wr_way_i] <= wr_line_i;
    end
  end

  // Status bits: cleared by reset, a line write always makes the way valid.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
      lru_q   <= '0;
    end else begin
      if (line_we_i) begin
        valid_q[wr_idx_i][wr_way_i] <= 1'b1;
        dirty_q[wr_idx_i][wr_way_i] <= wr_dirty_i;
      end
      if (lru_we_i) begin
        lru_q[wr_idx_i] <= lru_way_i;
      end
    end
  end

  // Combinational lookup of both ways of the addressed set.
  always_comb begin
    way_tag_o   = tag_q[rd_idx_i];
    way_line_o  = line_q[rd_idx_i];
    way_valid_o = valid_q[rd_idx_i];
    way_dirty_o = dirty_q[rd_idx_i];
    lru_o       = lru_q[rd_idx_i];
    match[0]    = way_valid_o[0] && (way_tag_o[0] == rd_tag_i);
    match[1]    = way_valid_o[1] && (way_tag_o[1] == rd_tag_i);
    hit_o       = |match;
    hit_way_o   = match[1];
  end

endmodule

// File: rtl/dcache_controller.sv
// 2-way set-associative, write-back, write-allocate data-cache controller for the
// MEM stage. Hits complete combinationally; misses run a write-back/refill FSM
// against a line-wide memory port with one-cycle enable/ack pulses.
module dcache_controller
  import dcache_controller_pkg::*;
#(
  parameter int unsigned SETS   = DefaultSets,
  parameter int unsigned LINE_W = 256,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [31:0]       cpu_data_i,
  input  logic              cpu_MemRead_i,
  input  logic              cpu_MemWrite_i,
  output logic [31:0]       cpu_data_o,
  output logic              cpu_stall_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i
);

  localparam int unsigned IdxW = $clog2(SETS);
  localparam int unsigned TagW = ADDR_W - OffsetW - IdxW;

  // Request decode
  logic                req;
  logic                is_store;
  logic [TagW-1:0]     req_tag;
  logic [IdxW-1:0]     req_idx;
  logic [WordSelW-1:0] req_word;
  logic [1:0]          unused_byte_off;

  assign req             = cpu_MemRead_i | cpu_MemWrite_i;
  assign is_store        = cpu_MemWrite_i;
  assign req_tag         = cpu_addr_i[ADDR_W-1 -: TagW];
  assign req_idx         = cpu_addr_i[OffsetW +: IdxW];
  assign req_word        = cpu_addr_i[2 +: WordSelW];
  assign unused_byte_off = cpu_addr_i[1:0];

  // Storage interface
  logic                   hit;
  logic                   hit_way;
  logic [1:0]             way_valid;
  logic [1:0]             way_dirty;
  logic [1:0][TagW-1:0]   way_tag;
  logic [1:0][LINE_W-1:0] way_line;
  logic                   lru;
  logic [IdxW-1:0]        wr_idx;
  logic                   line_we;
  logic                   wr_way;
  logic [TagW-1:0]        wr_tag;
  logic [LINE_W-1:0]      wr_line;
  logic                   wr_dirty;
  logic                   lru_we;
  logic                   lru_way;

  // FSM and miss context
  logic [2:0]        state_q, state_d;
  logic [TagW-1:0]   tag_q, tag_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic              victim_q, victim_d;
  logic              wb_q, wb_d;
  logic              rd_pend_q, rd_pend_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [LINE_W-1:0] mem_data_q, mem_data_d;

  logic              victim;
  logic              victim_dirty;
  logic [LINE_W-1:0] hit_line;
  logic [LINE_W-1:0] store_line;
  logic [31:0]       hit_word;

  dcache_sram #(
    .SETS  (SETS),
    .LINE_W(LINE_W),
    .TAG_W (TagW),
    .IDX_W (IdxW)
  ) u_sram (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .rd_idx_i   (req_idx),
    .rd_tag_i   (req_tag),
    .hit_o      (hit),
    .hit_way_o  (hit_way),
    .way_valid_o(way_valid),
    .way_dirty_o(way_dirty),
    .way_tag_o  (way_tag),
    .way_line_o (way_line),
    .lru_o      (lru),
    .wr_idx_i   (wr_idx),
    .line_we_i  (line_we),
    .wr_way_i   (wr_way),
    .wr_tag_i   (wr_tag),
    .wr_line_i  (wr_line),
    .wr_dirty_i (wr_dirty),
    .lru_we_i   (lru_we),
    .lru_way_i  (lru_way)
  );

  // Hit-path word select and store merge.
  always_comb begin
    hit_line   = way_line[hit_way];
    hit_word   = hit_line[{req_word, 5'b00000} +: WordW];
    store_line = hit_line;
    store_line[{req_word, 5'b00000} +: WordW] = cpu_data_i;
    victim       = pick_victim(way_valid, lru);
    victim_dirty = way_valid[victim] & way_dirty[victim];
  end

  // Next-state, storage writes and all outputs.
  always_comb begin
    state_d    = state_q;
    tag_d      = tag_q;
    idx_d      = idx_q;
    victim_d   = victim_q;
    wb_d       = wb_q;
    rd_pend_d  = rd_pend_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;

    wr_idx   = req_idx;
    line_we  = 1'b0;
    wr_way   = hit_way;
    wr_tag   = req_tag;
    wr_line  = store_line;
    wr_dirty = 1'b1;
    lru_we   = 1'b0;
    lru_way  = ~hit_way;

    cpu_stall_o  = 1'b1;
    cpu_data_o   = '0;
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;

    case (state_q)
      StIdle: begin
        cpu_stall_o = req & ~hit;
        if (req && hit) begin
          cpu_data_o = hit_word;
          lru_we     = 1'b1;
          line_we    = is_store;
        end else if (req) begin
          state_d   = StMiss;
          tag_d     = req_tag;
          idx_d     = req_idx;
          victim_d  = victim;
          wb_d      = victim_dirty;
          rd_pend_d = 1'b0;
          if (victim_dirty) begin
            mem_addr_d = {way_tag[victim], req_idx, {OffsetW{1'b0}}};
            mem_data_d = way_line[victim];
          end else begin
            mem_addr_d = {req_tag, req_idx, {OffsetW{1'b0}}};
          end
        end
      end
      StMiss: begin
        mem_enable_o = 1'b1;
        mem_write_o  = wb_q;
        state_d      = wb_q ? StWriteback : StRefill;
      end
      StWriteback: begin
        if (mem_ack_i) begin
          // The refill read is issued from the first REFILL cycle.
          mem_addr_d = {tag_q, idx_q, {OffsetW{1'b0}}};
          rd_pend_d  = 1'b1;
          state_d    = StRefill;
        end
      end
      StRefill: begin
        mem_enable_o = rd_pend_q;
        rd_pend_d    = 1'b0;
        if (mem_ack_i) begin
          line_we  = 1'b1;
          wr_idx   = idx_q;
          wr_way   = victim_q;
          wr_tag   = tag_q;
          wr_line  = mem_data_i;
          wr_dirty = 1'b0;
          state_d  = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign mem_addr_o = mem_addr_q;
  assign mem_data_o = mem_data_q;

  // State and miss-context registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      tag_q      <= '0;
      idx_q      <= '0;
      victim_q   <= 1'b0;
      wb_q       <= 1'b0;
      rd_pend_q  <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
    end else begin
      state_q    <= state_d;
      tag_q      <= tag_d;
      idx_q      <= idx_d;
      victim_q   <= victim_d;
      wb_q       <= wb_d;
      rd_pend_q  <= rd_pend_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
    end
  end

endmodule

// File: tb/tb_dcache_controller.sv
// Bench for dcache_controller: directed scenarios plus random loads/stores checked
// against a recency-list cache model and a reference memory image.
module tb_dcache_controller;

  // Ack arrives this many cycles after the enable cycle.
  localparam int Lat = 6;

  logic         clk;
  logic         rst_i;
  logic [31:0]  cpu_addr_i;
  logic [31:0]  cpu_data_i;
  logic         cpu_MemRead_i;
  logic         cpu_MemWrite_i;
  logic [31:0]  cpu_data_o;
  logic         cpu_stall_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic         mem_enable_o;
  logic         mem_write_o;
  logic [255:0] mem_data_i;
  logic         mem_ack_i;

  dcache_controller #(
    .SETS  (16),
    .LINE_W(256),
    .ADDR_W(32)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .cpu_addr_i    (cpu_addr_i),
    .cpu_data_i    (cpu_data_i),
    .cpu_MemRead_i (cpu_MemRead_i),
    .cpu_MemWrite_i(cpu_MemWrite_i),
    .cpu_data_o    (cpu_data_o),
    .cpu_stall_o   (cpu_stall_o),
    .mem_addr_o    (mem_addr_o),
    .mem_data_o    (mem_data_o),
    .mem_enable_o  (mem_enable_o),
    .mem_write_o   (mem_write_o),
    .mem_data_i    (mem_data_i),
    .mem_ack_i     (mem_ack_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0]  addr;
    logic         wr;
    logic [255:0] data;
  } txn_t;

  typedef struct {
    logic [3:0]   idx;
    logic [22:0]  tag;
    logic         dirty;
    logic [255:0] line;
  } entry_t;

  int unsigned  n_assert = 0;
  int unsigned  n_fail   = 0;
  txn_t         txq[$];             // memory requests seen on the DUT port
  logic [255:0] backmem [int unsigned];  // memory image served to the DUT
  logic [255:0] refmem  [int unsigned];  // memory image the model expects
  entry_t       lines[$];           // cached lines, most recently used first

  function automatic logic [255:0] default_line(input logic [31:0] la);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = la ^ (32'(w) * 32'h9E37_79B9) ^ 32'h5A5A_0000;
    return l;
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Memory responder: records each enable pulse and acks Lat cycles later.
  initial begin
    int   rem;
    txn_t pend;
    rem        = 0;
    mem_ack_i  = 1'b0;
    mem_data_i = '0;
    pend       = '{32'h0, 1'b0, 256'h0};
    forever begin
      @(posedge clk); #1;
      mem_ack_i = 1'b0;
      if (rem > 0) begin
        rem--;
        if (rem == 0) begin
          mem_ack_i = 1'b1;
          if (pend.wr) backmem[pend.addr] = pend.data;
          else mem_data_i = backmem.exists(pend.addr) ? backmem[pend.addr]
                                                      : default_line(pend.addr);
        end
      end
      @(negedge clk);
      if (mem_enable_o === 1'b1) begin
        pend = '{mem_addr_o, mem_write_o, mem_data_o};
        txq.push_back(pend);
        rem = Lat;
      end
    end
  end

  task automatic do_reset();
    rst_i          = 1'b1;
    cpu_MemRead_i  = 1'b0;
    cpu_MemWrite_i = 1'b0;
    @(posedge clk); #1;
    rst_i = 1'b0;
    lines.delete();
  endtask

  // One CPU access: predict from the model, drive, count stall cycles, compare.
  task automatic access(input logic [31:0] a, input logic rd, input logic wr,
                        input logic [31:0] wd, input string tag);
    logic [3:0]   idx;
    logic [22:0]  t;
    int           w, hit_i, vic, cnt, exp_stall, stalls;
    logic [31:0]  la, exp_data;
    entry_t       e;
    txn_t         exp_tx[$];
    idx   = a[8:5];
    t     = a[31:9];
    w     = int'(a[4:2]);
    hit_i = -1;
    vic   = -1;
    cnt   = 0;
    for (int i = 0; i < lines.size(); i++) begin
      if (lines[i].idx == idx) begin
        cnt++;
        vic = i;
        if (lines[i].tag == t) hit_i = i;
      end
    end
    if (hit_i >= 0) begin
      e = lines[hit_i];
      lines.delete(hit_i);
      exp_stall = 0;
    end else begin
      exp_stall = 3 + Lat;
      if (cnt == 2) begin
        if (lines[vic].dirty) begin
          la = {lines[vic].tag, idx, 5'b0};
          exp_tx.push_back('{la, 1'b1, lines[vic].line});
          refmem[la] = lines[vic].line;
          exp_stall  = 4 + 2 * Lat;
        end
        lines.delete(vic);
      end
      la      = {t, idx, 5'b0};
      e.idx   = idx;
      e.tag   = t;
      e.dirty = 1'b0;
      e.line  = refmem.exists(la) ? refmem[la] : default_line(la);
      exp_tx.push_back('{la, 1'b0, 256'h0});
    end
    if (wr) begin
      e.line[w*32 +: 32] = wd;
      e.dirty            = 1'b1;
    end
    exp_data = e.line[w*32 +: 32];
    lines.push_front(e);

    txq.delete();
    cpu_addr_i     = a;
    cpu_data_i     = wd;
    cpu_MemRead_i  = rd;
    cpu_MemWrite_i = wr;
    stalls         = 0;
    @(negedge clk);
    while (cpu_stall_o !== 1'b0 && stalls < 100) begin
      stalls++;
      @(posedge clk); #1;
      @(negedge clk);
    end
    chk({tag, " stall_cycles"}, 256'(stalls), 256'(exp_stall));
    if (rd && !wr) chk({tag, " load_data"}, cpu_data_o, exp_data);
    @(posedge clk); #1;
    cpu_MemRead_i  = 1'b0;
    cpu_MemWrite_i = 1'b0;
    chk({tag, " mem_txn_count"}, 256'(txq.size()), 256'(exp_tx.size()));
    for (int i = 0; i < exp_tx.size() && i < txq.size(); i++) begin
      chk({tag, " mem_addr"}, txq[i].addr, exp_tx[i].addr);
      chk({tag, " mem_write"}, txq[i].wr, exp_tx[i].wr);
      if (exp_tx[i].wr) chk({tag, " wb_line"}, txq[i].data, exp_tx[i].data);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] l;
    logic [31:0]  a;
    int           op, cyc;

    l = default_line(32'h40);
    l[31:0] = 32'h1111_2222;
    backmem[32'h40] = l;
    refmem[32'h40]  = l;

    cpu_addr_i     = '0;
    cpu_data_i     = '0;
    cpu_MemRead_i  = 1'b0;
    cpu_MemWrite_i = 1'b0;
    rst_i          = 1'b1;
    @(posedge clk); #1;
    do_reset();

    // Reset state
    @(negedge clk);
    chk("reset stall", cpu_stall_o, 1'b0);
    chk("reset mem_enable", mem_enable_o, 1'b0);
    chk("reset mem_write", mem_write_o, 1'b0);
    chk("reset cpu_data", cpu_data_o, 32'h0);
    chk("reset mem_addr", mem_addr_o, 32'h0);
    chk("reset mem_data", mem_data_o, 256'h0);
    @(posedge clk); #1;

    // Cold load, store hit, load-after-store hit
    access(32'h40, 1'b1, 1'b0, 32'h0, "cold_load_40");
    access(32'h44, 1'b0, 1'b1, 32'hDEAD_BEEF, "store_hit_44");
    access(32'h44, 1'b1, 1'b0, 32'h0, "load_hit_44");

    // Third tag in set 2 evicts the dirty 0x40 line
    access(32'h240, 1'b1, 1'b0, 32'h0, "fill_240");
    access(32'h440, 1'b1, 1'b0, 32'h0, "evict_dirty_40");

    // LRU picks the clean 0x240 line
    do_reset();
    access(32'h40, 1'b1, 1'b0, 32'h0, "lru_40");
    access(32'h240, 1'b1, 1'b0, 32'h0, "lru_240");
    access(32'h40, 1'b1, 1'b0, 32'h0, "lru_40_again");
    access(32'h440, 1'b1, 1'b0, 32'h0, "lru_evict_240");
    access(32'h40, 1'b1, 1'b0, 32'h0, "lru_40_kept");

    // Reset while in REFILL; the late ack must be ignored
    do_reset();
    cpu_addr_i    = 32'h840;
    cpu_MemRead_i = 1'b1;
    cyc = 0;
    @(negedge clk);
    while (mem_enable_o !== 1'b1 && cyc < 20) begin
      cyc++;
      @(negedge clk);
    end
    chk("midreset read_pulse", mem_enable_o, 1'b1);
    chk("midreset read_addr", mem_addr_o, 32'h840);
    chk("midreset read_write", mem_write_o, 1'b0);
    @(posedge clk); #1;
    rst_i         = 1'b1;
    cpu_MemRead_i = 1'b0;
    @(posedge clk); #1;
    rst_i = 1'b0;
    lines.delete();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("midreset stall_low", cpu_stall_o, 1'b0);
      chk("midreset no_enable", mem_enable_o, 1'b0);
    end
    @(posedge clk); #1;
    access(32'h840, 1'b1, 1'b0, 32'h0, "after_reset_miss_840");

    // Read+write together is a store
    access(32'h844, 1'b1, 1'b1, 32'hCAFE_F00D, "rdwr_store_844");
    access(32'h844, 1'b1, 1'b0, 32'h0, "load_844");
    access(32'hA40, 1'b1, 1'b0, 32'h0, "fill_A40");
    access(32'hC40, 1'b1, 1'b0, 32'h0, "evict_dirty_840");

    // Random traffic over a few sets and tags
    for (int k = 0; k < 60; k++) begin
      a  = 32'(($urandom_range(0, 3) << 9) | ($urandom_range(0, 3) << 5) |
               ($urandom_range(0, 7) << 2));
      op = int'($urandom_range(0, 2));
      access(a, op != 1, op != 0, $urandom, "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
